timestamp_readout: RTL and testbench

Capture-and-readout companion to the timestamp counter. On each rising edge of a capture strobe it snapshots the free-running 48-bit time value into a small FIFO. The host drains that FIFO as 16-bit words, MSB word first. The word order is the same as the host's 16-bit load path into the 48-bit down-counter, so one 3-word transfer format serves both directions. The block sits in the `clk` domain, between the 48-bit up-counter output and the host pipe-out logic.

---
 rtl/timestamp_readout.sv | 131 +++++++++++++
 tb/tb_timestamp_readout.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_readout.sv
// timestamp_readout: snapshots the 48-bit time value on each rising edge of
// the capture strobe into a small FIFO, and presents the head entry to the
// host as three 16-bit words, most significant word first.
//
// Word-phase FSM
//   state  | meaning
//   PH_HI  | head[47:32] on data_out; next read advances
//   PH_MID | head[31:16] on data_out; next read advances
//   PH_LO  | head[15:0]  on data_out; next read pops the entry
module timestamp_readout #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          capture,
    input  logic [47:0]   time_in,
    input  logic          data_read,
    input  logic          clr_ovf,
    output logic [15:0]   data_out,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic [AW:0]   count
);

    typedef enum logic [1:0] {
        PH_HI  = 2'd0,
        PH_MID = 2'd1,
        PH_LO  = 2'd2
    } phase_t;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    phase_t          phase_q, phase_d;
    logic            cap_q;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [47:0]     mem_q [DEPTH];
    logic [47:0]     head;

    logic            cap_evt;
    logic            rd_ok;
    logic            pop;
    logic            push;
    logic            drop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign overflow = ovf_q;

    // A full FIFO still accepts a capture when the same cycle retires the head.
    assign cap_evt = capture & ~cap_q;
    assign rd_ok   = data_read & ~empty;
    assign pop     = rd_ok & (phase_q == PH_LO);
    assign push    = cap_evt & (~full | pop);
    assign drop    = cap_evt & ~push;

    // Word-phase next state: advance on each accepted host read, wrap after the low word.
    always_comb begin
        phase_d = phase_q;
        if (rd_ok) begin
            case (phase_q)
                PH_HI:   phase_d = PH_MID;
                PH_MID:  phase_d = PH_LO;
                default: phase_d = PH_HI;
            endcase
        end
    end

    // Pointer, occupancy and sticky-overflow next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (clr_ovf) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    // Head-word mux; forced to zero while nothing is stored.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        data_out = '0;
        if (!empty) begin
            case (phase_q)
                PH_HI:   data_out = head[47:32];
                PH_MID:  data_out = head[31:16];
                PH_LO:   data_out = head[15:0];
                default: data_out = '0;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q  <= PH_HI;
            cap_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cap_q    <= capture;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage is never cleared; a capture during reset is not written.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= time_in;
    end

endmodule

// File: tb/tb_timestamp_readout.sv
// Bench for timestamp_readout: an entry-level queue model predicts FIFO state;
// accepted captures push their three words into a scoreboard that the
// monitor pops on every host word read.
module tb_timestamp_readout;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          capture = 1'b0;
    logic [47:0]   time_in = '0;
    logic          data_read = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [15:0]   data_out;
    logic          empty;
    logic          full;
    logic          overflow;
    logic [AW:0]   count;

    timestamp_readout #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (capture),
        .time_in   (time_in),
        .data_read (data_read),
        .clr_ovf   (clr_ovf),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [47:0] m_fifo[$];
    logic [15:0] sb[$];
    int          m_words_done = 0;
    bit          m_ovf = 0;
    bit          m_prev_cap = 0;
    bit          started = 0;
    bit          track_max = 0;
    int          max_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [47:0] e, input int w);
        case (w)
            0:       return e[47:32];
            1:       return e[31:16];
            default: return e[15:0];
        endcase
    endfunction

    // Monitor + reference model: inputs are stable at negedge and are what the next posedge samples.
    always @(negedge clk) begin
        logic [15:0] exp_head;
        logic [15:0] exp_word;
        int          sz;
        bit          evt, pop_now;
        if (started) begin
            sz = m_fifo.size();
            exp_head = (sz == 0) ? 16'h0000 : word_of(m_fifo[0], m_words_done);
            chk("count", 64'(count), 64'(sz));
            chk("empty", 64'(empty), 64'(sz == 0));
            chk("full", 64'(full), 64'(sz == DEPTH));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("data_out_head", 64'(data_out), 64'(exp_head));
            if (track_max && int'(count) > max_cnt) max_cnt = int'(count);
        end
        if (!rst_n) begin
            m_fifo.delete();
            sb.delete();
            m_words_done = 0;
            m_ovf = 0;
            m_prev_cap = 0;
            started = 1;
        end else if (started) begin
            sz = m_fifo.size();
            evt = capture && !m_prev_cap;
            m_prev_cap = capture;
            pop_now = 0;
            if (data_read && sz > 0) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_nonempty", 64'(0), 64'(1));
                end else begin
                    exp_word = sb.pop_front();
                    chk("read_word", 64'(data_out), 64'(exp_word));
                end
                if (m_words_done == 2) begin
                    m_words_done = 0;
                    void'(m_fifo.pop_front());
                    pop_now = 1;
                end else begin
                    m_words_done++;
                end
            end
            if (clr_ovf) m_ovf = 0;
            if (evt) begin
                if (sz < DEPTH || pop_now) begin
                    m_fifo.push_back(time_in);
                    for (int w = 0; w < 3; w++) sb.push_back(word_of(time_in, w));
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cap_pulse(input logic [47:0] v);
        time_in = v;
        capture = 1'b1;
        cyc();
        capture = 1'b0;
        cyc();
    endtask

    task automatic read_words(input int n);
        data_read = 1'b1;
        cyc(n);
        data_read = 1'b0;
        cyc();
    endtask

    initial begin
        logic [47:0] r;
        cyc(3);
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_data_out", 64'(data_out), 64'(0));
        rst_n = 1'b1;
        cyc();

        // Single capture with capture held high for 5 cycles.
        time_in = 48'h1234_5678_9ABC;
        capture = 1'b1;
        cyc(5);
        capture = 1'b0;
        cyc();
        chk("single_count", 64'(count), 64'(1));
        chk("single_w0", 64'(data_out), 64'h1234);
        data_read = 1'b1; cyc();
        chk("single_w1", 64'(data_out), 64'h5678);
        cyc();
        chk("single_w2", 64'(data_out), 64'h9ABC);
        cyc();
        data_read = 1'b0;
        chk("single_after_empty", 64'(empty), 64'(1));
        chk("single_after_data", 64'(data_out), 64'(0));
        cyc();

        // Fill to full, then one more capture overflows.
        for (int i = 1; i <= 9; i++) begin
            cap_pulse(48'(i));
            if (i == 8) chk("fill_full", 64'(full), 64'(1));
            if (i == 8) chk("fill_no_ovf", 64'(overflow), 64'(0));
        end
        chk("fill_ovf", 64'(overflow), 64'(1));
        chk("fill_count", 64'(count), 64'(8));
        read_words(24);
        chk("drain_empty", 64'(empty), 64'(1));
        clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0; cyc();
        chk("clr_ovf", 64'(overflow), 64'(0));

        // Collision at full: pop and capture in the same cycle.
        for (int i = 0; i < 8; i++) cap_pulse({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
        chk("coll_full", 64'(full), 64'(1));
        data_read = 1'b1; cyc(2);
        time_in = 48'hC0DE_CAFE_BEEF;
        capture = 1'b1;
        cyc();
        data_read = 1'b0;
        capture = 1'b0;
        cyc();
        chk("coll_count", 64'(count), 64'(8));
        chk("coll_ovf", 64'(overflow), 64'(0));
        read_words(24);
        chk("coll_drained", 64'(empty), 64'(1));

        // Reads on an empty FIFO must not move the word phase.
        read_words(4);
        cap_pulse(48'hFFFF_0000_AAAA);
        chk("empty_read_first", 64'(data_out), 64'hFFFF);
        read_words(3);

        // Reset in the middle of a transfer.
        cap_pulse(48'h1111_2222_3333);
        cap_pulse(48'h4444_5555_6666);
        cap_pulse(48'h7777_8888_9999);
        read_words(1);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        chk("mid_rst_count", 64'(count), 64'(0));
        chk("mid_rst_empty", 64'(empty), 64'(1));
        chk("mid_rst_ovf", 64'(overflow), 64'(0));
        cyc();
        cap_pulse(48'h0000_0000_0001);
        chk("mid_rst_w0", 64'(data_out), 64'h0000);
        read_words(3);

        // Wrap-around: 20 bursts of 3 random captures, each fully drained.
        track_max = 1;
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < 3; k++) begin
                r = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
                cap_pulse(r);
            end
            read_words(9);
        end
        track_max = 0;
        chk("wrap_max_count_le3", 64'(max_cnt <= 3), 64'(1));
        chk("wrap_max_count_seen3", 64'(max_cnt), 64'(3));
        chk("sb_drained", 64'(sb.size()), 64'(0));
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
